lc_ctrl_state_fetch: RTL and testbench
======================================

Name: lc_ctrl_state_fetch

Overview:
Upstream feeder of the life cycle signal decoder. It fetches the life cycle state and transition count from the OTP controller over a req/ack interface, reading twice and comparing both reads. It checks the state against the legal encoding set and presents `lc_state_o`, `lc_cnt_o` and `lc_state_valid_o` to the decoder. On an unrecoverable fetch fault it raises a sticky escalation request.

Parameters:
- NumRetries, 3, maximum re-fetch attempts after a mismatch or error before entering ErrorSt (1..15).
- TimeoutCycles, 1024, maximum cycles a single read waits for `otp_ack_i` (2..65535).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `otp_req_o` out 1: OTP read request; held high until ack.
- `otp_ack_i` in 1: OTP read acknowledge; data is valid in this cycle.
- `otp_state_i` in LcStateWidth: raw life cycle state word.
- `otp_cnt_i` in LcCountWidth: raw transition count word.
- `otp_err_i` in 1: OTP read error; sampled together with `otp_ack_i`.
- `refresh_i` in 1: single-cycle request to re-fetch; honoured only in ValidSt.
- `lc_state_valid_o` out 1: `lc_state_o` and `lc_cnt_o` are checked and stable.
- `lc_state_o` out LcStateWidth: fetched life cycle state (type `lc_state_e`).
- `lc_cnt_o` out LcCountWidth: fetched transition count.
- `fetch_err_o` out 1: sticky fetch-failure flag.
- `escalate_req_o` out 1: sticky escalation request to the life cycle FSM.

Behaviour:
- Reset (`rst_i`=1 at a clock edge): FSM goes to IdleSt; retry and timeout counters go to 0; capture registers are cleared. Output reset values:
  - `otp_req_o`=0, `lc_state_valid_o`=0, `fetch_err_o`=0, `escalate_req_o`=0.
  - `lc_state_o`=LcStInvalidVal, `lc_cnt_o`=LcCntInvalidVal.
- Reset asserted in any state aborts the operation immediately. The OTP transaction in flight is dropped; any late ack is ignored because `otp_req_o`=0.
- All outputs are registered. `otp_req_o` is a decode of the FSM state flop.
- FSM states:
  - IdleSt: always moves to Read0St on the next cycle.
  - Read0St: `otp_req_o`=1. On ack, capture `{otp_state_i, otp_cnt_i}` into snapshot A, OR `otp_err_i` into err_seen, then go to Read1St.
  - Read1St: same as Read0St, but captures into snapshot B. On ack, go to CheckSt.
  - CheckSt: one cycle. Pass if A==B, err_seen=0 and A.state is in the legal set (package function `lc_state_is_legal`).
    - Pass, first fetch: go to ValidSt and load the outputs.
    - Pass during a refresh: the fetched value must equal the held output. Equal → ValidSt; different → ErrorSt, because the state may change only across a reset.
    - Fail with retry_cnt < NumRetries: retry_cnt++, clear err_seen, go to Read0St.
    - Fail with retry_cnt == NumRetries: go to ErrorSt.
  - ValidSt: `lc_state_valid_o`=1; retry_cnt is cleared on entry. `refresh_i`=1 → Read0St. During a refresh the outputs and `lc_state_valid_o` stay at their held values.
  - ErrorSt: terminal until reset. `lc_state_valid_o`=0, `lc_state_o`=LcStInvalidVal, `fetch_err_o`=1, `escalate_req_o`=1. `refresh_i` is ignored.
- Timeout: the counter increments each cycle in Read0St/Read1St without ack and clears on ack or state exit. When it reaches TimeoutCycles-1 with no ack, go to ErrorSt directly, with no retry. `otp_req_o` drops in the same cycle ErrorSt is entered.
- Handshake: ack may arrive in the first cycle of req. A new request may start in the cycle after ack, so back-to-back transactions are allowed. `otp_ack_i` is ignored whenever `otp_req_o`=0.
- Latency, with zero-wait ack, from the first edge with `rst_i`=0:
  - cycle 1: Read0St;
  - cycle 2: Read1St;
  - cycle 3: CheckSt;
  - cycle 4: `lc_state_valid_o`=1.
- `refresh_i` asserted in any state other than ValidSt is ignored; it is not queued.
- Simultaneous ack and timeout terminal count: the ack wins.
- Outputs are never updated with unchecked data. `lc_state_valid_o` never rises on the same cycle as `fetch_err_o`.

Decomposition:
- Add to `lc_ctrl_state_pkg`:
  - `LcStInvalidVal` and `LcCntInvalidVal`, both random netlist constants that are not legal encodings;
  - function `lc_state_is_legal(lc_state_e)`;
  - enum `fetch_state_e` with sparse encoding and Hamming distance ≥3.
- Sub-module: `lc_ctrl_fetch_timer`, which holds the timeout counter and its terminal-count flag.

Test Plan:
1. Reset release; OTP returns LcStProd/cnt 5 with zero-wait ack on both reads → `lc_state_valid_o`=1 at cycle 4, `lc_state_o`=LcStProd, `lc_cnt_o`=5, `escalate_req_o`=0.
2. First read LcStDev, second read LcStRma, then two matching LcStDev reads → one retry; valid with LcStDev at cycle 7; `fetch_err_o`=0.
3. Every second read mismatches, with NumRetries=3 → 4 compare attempts, then ErrorSt; `fetch_err_o`=`escalate_req_o`=1, valid=0, `lc_state_o`=LcStInvalidVal.
4. Ack withheld for 1024 cycles in Read1St → `otp_req_o` drops and ErrorSt is entered exactly at the terminal count; an ack on the same cycle instead → proceeds to CheckSt.
5. Illegal state word on both reads, or `otp_err_i`=1 on one ack → treated as a fail and retried; valid never asserts with the illegal value.
6. In ValidSt (LcStProd): pulse `refresh_i`, OTP returns LcStProd → valid stays high throughout. Pulse again, OTP returns LcStDev → ErrorSt. Then assert `rst_i` mid-Read0St → all outputs at reset values on the next cycle, and the fetch restarts.

Source files
------------

// File: rtl/lc_ctrl_state_pkg.sv
// Shared types and constants for life cycle state fetch: state encodings,
// invalid markers, snapshot layout and the sparse fetch FSM encoding.
package lc_ctrl_state_pkg;

  localparam int LcStateWidth = 32;
  localparam int LcCountWidth = 16;

  typedef enum logic [LcStateWidth-1:0] {
    LcStRaw           = 32'h3A5C_0F91,
    LcStTestUnlocked0 = 32'h96E1_4B27,
    LcStDev           = 32'h5D2B_E8C4,
    LcStProd          = 32'hC7A3_1D6E,
    LcStProdEnd       = 32'h0B9F_72A5,
    LcStRma           = 32'hE46D_9C38,
    LcStScrap         = 32'h71F8_A65B
  } lc_state_e;

  // Neither word appears among the legal encodings above.
  localparam logic [LcStateWidth-1:0] LcStInvalidVal  = 32'hA4C2_5E3D;
  localparam logic [LcCountWidth-1:0] LcCntInvalidVal = 16'hB6D9;

  typedef struct packed {
    logic [LcStateWidth-1:0] state;
    logic [LcCountWidth-1:0] cnt;
  } lc_snap_t;

  // Pairwise Hamming distance of at least 3 between all codes.
  typedef enum logic [5:0] {
    IdleSt  = 6'b000000,
    Read0St = 6'b000111,
    Read1St = 6'b111000,
    CheckSt = 6'b011011,
    ValidSt = 6'b101101,
    ErrorSt = 6'b110110
  } fetch_state_e;

  function automatic logic lc_state_is_legal(lc_state_e st);
    logic legal;
    case (st)
      LcStRaw, LcStTestUnlocked0, LcStDev, LcStProd,
      LcStProdEnd, LcStRma, LcStScrap: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lc_ctrl_state_fetch_timer.sv
// Per-read timeout counter: counts cycles of an outstanding OTP request and
// flags the terminal count combinationally from the counter flop.
module lc_ctrl_fetch_timer #(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic tc_o
);

  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] TcVal = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != TcVal) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = active_i && (cnt_q == TcVal);

endmodule

// File: rtl/lc_ctrl_state_fetch.sv
// Double-read fetch of life cycle state/count from OTP with legality check,
// bounded retries and a sticky escalation; valid 4 cycles after reset at best.
module lc_ctrl_state_fetch
  import lc_ctrl_state_pkg::*;
#(
  parameter int NumRetries    = 3,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    otp_req_o,
  input  logic                    otp_ack_i,
  input  logic [LcStateWidth-1:0] otp_state_i,
  input  logic [LcCountWidth-1:0] otp_cnt_i,
  input  logic                    otp_err_i,
  input  logic                    refresh_i,
  output logic                    lc_state_valid_o,
  output logic [LcStateWidth-1:0] lc_state_o,
  output logic [LcCountWidth-1:0] lc_cnt_o,
  output logic                    fetch_err_o,
  output logic                    escalate_req_o
);

  localparam logic [3:0] RetryMax = 4'(NumRetries);

  fetch_state_e            state_d, state_q;
  logic [3:0]              retry_d, retry_q;
  logic                    err_seen_d, err_seen_q;
  lc_snap_t                snap_a_d, snap_a_q;
  lc_snap_t                snap_b_d, snap_b_q;
  logic                    valid_d, valid_q;
  logic [LcStateWidth-1:0] lc_state_d, lc_state_q;
  logic [LcCountWidth-1:0] lc_cnt_d, lc_cnt_q;
  logic                    fetch_err_d, fetch_err_q;
  logic                    escalate_d, escalate_q;

  logic     ack_vld;
  logic     tmo_tc;
  logic     chk_pass;
  logic     held_match;
  lc_snap_t rd_snap;

  assign otp_req_o  = (state_q == Read0St) || (state_q == Read1St);
  assign ack_vld    = otp_ack_i && otp_req_o;
  assign rd_snap    = {otp_state_i, otp_cnt_i};
  assign chk_pass   = (snap_a_q == snap_b_q) && !err_seen_q &&
                      lc_state_is_legal(lc_state_e'(snap_a_q.state));
  assign held_match = (snap_a_q.state == lc_state_q) && (snap_a_q.cnt == lc_cnt_q);

  lc_ctrl_fetch_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (otp_req_o),
    .ack_i    (ack_vld),
    .tc_o     (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    err_seen_d  = err_seen_q;
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    valid_d     = valid_q;
    lc_state_d  = lc_state_q;
    lc_cnt_d    = lc_cnt_q;
    fetch_err_d = fetch_err_q;
    escalate_d  = escalate_q;

    case (state_q)
      IdleSt: state_d = Read0St;
      Read0St: begin
        if (ack_vld) begin
          snap_a_d   = rd_snap;
          err_seen_d = err_seen_q | otp_err_i;
          state_d    = Read1St;
        end else if (tmo_tc) begin
          state_d = ErrorSt;
        end
      end
      Read1St: begin
        if (ack_vld) begin
          snap_b_d   = rd_snap;
          err_seen_d = err_seen_q | otp_err_i;
          state_d    = CheckSt;
        end else if (tmo_tc) begin
          state_d = ErrorSt;
        end
      end
      CheckSt: begin
        // valid_q still high here means this fetch is a refresh of held data.
        if (chk_pass) begin
          if (!valid_q) begin
            state_d    = ValidSt;
            retry_d    = '0;
            valid_d    = 1'b1;
            lc_state_d = snap_a_q.state;
            lc_cnt_d   = snap_a_q.cnt;
          end else if (held_match) begin
            state_d = ValidSt;
            retry_d = '0;
          end else begin
            state_d = ErrorSt;
          end
        end else if (retry_q < RetryMax) begin
          retry_d    = retry_q + 4'd1;
          err_seen_d = 1'b0;
          state_d    = Read0St;
        end else begin
          state_d = ErrorSt;
        end
      end
      ValidSt: begin
        if (refresh_i) begin
          state_d = Read0St;
        end
      end
      ErrorSt: state_d = ErrorSt;
      default: state_d = ErrorSt;
    endcase

    if (state_d == ErrorSt) begin
      valid_d     = 1'b0;
      lc_state_d  = LcStInvalidVal;
      fetch_err_d = 1'b1;
      escalate_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IdleSt;
      retry_q     <= '0;
      err_seen_q  <= 1'b0;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      valid_q     <= 1'b0;
      lc_state_q  <= LcStInvalidVal;
      lc_cnt_q    <= LcCntInvalidVal;
      fetch_err_q <= 1'b0;
      escalate_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      err_seen_q  <= err_seen_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      valid_q     <= valid_d;
      lc_state_q  <= lc_state_d;
      lc_cnt_q    <= lc_cnt_d;
      fetch_err_q <= fetch_err_d;
      escalate_q  <= escalate_d;
    end
  end

  assign lc_state_valid_o = valid_q;
  assign lc_state_o       = lc_state_q;
  assign lc_cnt_o         = lc_cnt_q;
  assign fetch_err_o      = fetch_err_q;
  assign escalate_req_o   = escalate_q;

endmodule

// File: tb/tb_lc_ctrl_state_fetch.sv
// Bench for lc_ctrl_state_fetch: scripted OTP responder, vector table,
// hand sequences for refresh/reset/timeout and a randomized fetch model.
module tb_lc_ctrl_state_fetch;
  import lc_ctrl_state_pkg::*;

  localparam int NUM_RETRIES = 3;
  localparam int TIMEOUT     = 1024;
  localparam int NVEC        = 13;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        otp_req_o;
  logic        otp_ack_i = 1'b0;
  logic [31:0] otp_state_i = '0;
  logic [15:0] otp_cnt_i = '0;
  logic        otp_err_i = 1'b0;
  logic        refresh_i = 1'b0;
  logic        lc_state_valid_o;
  logic [31:0] lc_state_o;
  logic [15:0] lc_cnt_o;
  logic        fetch_err_o;
  logic        escalate_req_o;

  int checks = 0;
  int failures = 0;

  lc_ctrl_state_fetch #(.NumRetries(NUM_RETRIES), .TimeoutCycles(TIMEOUT)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .otp_req_o        (otp_req_o),
    .otp_ack_i        (otp_ack_i),
    .otp_state_i      (otp_state_i),
    .otp_cnt_i        (otp_cnt_i),
    .otp_err_i        (otp_err_i),
    .refresh_i        (refresh_i),
    .lc_state_valid_o (lc_state_valid_o),
    .lc_state_o       (lc_state_o),
    .lc_cnt_o         (lc_cnt_o),
    .fetch_err_o      (fetch_err_o),
    .escalate_req_o   (escalate_req_o)
  );

  always #5 clk_i = ~clk_i;

  // Index 0..6 are the legal states, index 7 an illegal word.
  logic [31:0] st_word [8] = '{LcStRaw, LcStTestUnlocked0, LcStDev, LcStProd,
                               LcStProdEnd, LcStRma, LcStScrap, 32'h1234_5678};

  function automatic bit is_legal(input logic [31:0] w);
    for (int k = 0; k < 7; k++) if (w == st_word[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Scripted OTP reads: one entry per acknowledged read, delay in wait cycles.
  logic [31:0] rq_st [$];
  logic [15:0] rq_cnt[$];
  bit          rq_err[$];
  int          rq_dly[$];
  int          wcnt = 0;

  always @(negedge clk_i) begin
    otp_ack_i = 1'b0;
    otp_err_i = 1'b0;
    if (rst_i) begin
      wcnt = 0;
    end else if (otp_req_o === 1'b1) begin
      if (rq_dly.size() > 0 && wcnt >= rq_dly[0]) begin
        otp_ack_i   = 1'b1;
        otp_state_i = rq_st.pop_front();
        otp_cnt_i   = rq_cnt.pop_front();
        otp_err_i   = rq_err.pop_front();
        void'(rq_dly.pop_front());
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i && lc_state_valid_o === 1'b1) begin
      checks++;
      if (fetch_err_o !== 1'b0 || !is_legal(lc_state_o)) begin
        failures++;
        $display("FAIL valid_integrity: err=%0b state=0x%0h, required err=0 and a legal state",
                 fetch_err_o, lc_state_o);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_q();
    rq_st.delete(); rq_cnt.delete(); rq_err.delete(); rq_dly.delete();
  endtask

  task automatic push_rd(input logic [31:0] s, input logic [15:0] c, input bit e, input int d);
    rq_st.push_back(s); rq_cnt.push_back(c); rq_err.push_back(e); rq_dly.push_back(d);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    refresh_i = 1'b0;
    clear_q();
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req"},   otp_req_o, 0);
    chk({tag, " valid"}, lc_state_valid_o, 0);
    chk({tag, " err"},   fetch_err_o, 0);
    chk({tag, " esc"},   escalate_req_o, 0);
    chk({tag, " state"}, lc_state_o, LcStInvalidVal);
    chk({tag, " cnt"},   lc_cnt_o, LcCntInvalidVal);
  endtask

  // Attempt-level model: each compare attempt is two reads plus one check cycle,
  // a read with delay d occupies d+1 cycles, and d >= TIMEOUT means no ack in time.
  // Cycle 1 is the first edge in Read0; dec is the edge the outcome appears.
  task automatic model(input bit refresh, input logic [31:0] hs, input logic [15:0] hc,
                       output bit ok, output int dec, output int lastreq,
                       output logic [31:0] es, output logic [15:0] ec);
    int t; int i; int d; bit e;
    logic [31:0] s0, s1; logic [15:0] c0, c1;
    t = 1; i = 0; ok = 1'b0; dec = 0; lastreq = 0; es = '0; ec = '0;
    for (int a = 0; a <= NUM_RETRIES; a++) begin
      e = 1'b0; s0 = '0; s1 = '0; c0 = '0; c1 = '0;
      for (int r = 0; r < 2; r++) begin
        d = (i < rq_dly.size()) ? rq_dly[i] : (1 << 30);
        if (d >= TIMEOUT) begin
          ok = 1'b0; dec = t + TIMEOUT; lastreq = dec - 1;
          return;
        end
        if (r == 0) begin s0 = rq_st[i]; c0 = rq_cnt[i]; end
        else        begin s1 = rq_st[i]; c1 = rq_cnt[i]; end
        e = e | rq_err[i];
        i++;
        t += d + 1;
      end
      dec = t + 1;
      lastreq = t - 1;
      if (s0 == s1 && c0 == c1 && !e && is_legal(s0)) begin
        ok = !refresh || (s0 == hs && c0 == hc);
        es = s0; ec = c0;
        return;
      end
      t = dec;
    end
    ok = 1'b0;
  endtask

  task automatic observe(input string nm, input bit refresh, input bit ok, input int dec,
                         input int lastreq, input logic [31:0] es, input logic [15:0] ec);
    int first_v; int first_e; int last_r; bit all_v;
    first_v = -1; first_e = -1; last_r = -1; all_v = 1'b1;
    for (int k = 1; k <= dec + 4; k++) begin
      @(posedge clk_i); @(negedge clk_i);
      if (k == 1) refresh_i = 1'b0;
      if (lc_state_valid_o === 1'b1 && first_v < 0) first_v = k;
      if (lc_state_valid_o !== 1'b1 && (ok || k < dec)) all_v = 1'b0;
      if (fetch_err_o === 1'b1 && first_e < 0) first_e = k;
      if (otp_req_o === 1'b1) last_r = k;
    end
    if (refresh) chk({nm, " valid_held"}, all_v, 1);
    else         chk({nm, " valid_cycle"}, first_v, ok ? dec : -1);
    chk({nm, " err_cycle"}, first_e, ok ? -1 : dec);
    chk({nm, " last_req"}, last_r, lastreq);
    if (ok) begin
      chk({nm, " state"}, lc_state_o, es);
      chk({nm, " cnt"},   lc_cnt_o, ec);
      chk({nm, " esc"},   escalate_req_o, 0);
    end else begin
      chk({nm, " state"}, lc_state_o, LcStInvalidVal);
      chk({nm, " valid"}, lc_state_valid_o, 0);
      chk({nm, " esc"},   escalate_req_o, 1);
      chk({nm, " req"},   otp_req_o, 0);
    end
  endtask

  task automatic gen_read(input logic [31:0] bs, input logic [15:0] bc);
    logic [31:0] s; logic [15:0] c;
    s = ($urandom_range(0, 9) < 7) ? bs : st_word[$urandom_range(0, 7)];
    c = ($urandom_range(0, 9) < 8) ? bc : 16'($urandom);
    push_rd(s, c, $urandom_range(0, 9) == 0, $urandom_range(0, 3));
  endtask

  typedef struct packed {
    logic [3:0]  n;
    logic [29:0] st;
    logic [9:0]  er;
    logic [9:0]  cm;
    logic [1:0]  dly;
    logic [15:0] cnt;
    logic        ok;
    logic [2:0]  est;
    logic [11:0] dec;
    logic [11:0] lastreq;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    bit m_ok; int m_dec; int m_lr; logic [31:0] m_es; logic [15:0] m_ec;
    logic [31:0] bs; logic [15:0] bc;

    // Read k uses octal digit k (lowest first); cm flips cnt bit 0 for read k.
    tbl[0]  = '{n:2, st:30'o33,       er:0,  cm:0, dly:0, cnt:5,      ok:1, est:3, dec:4,    lastreq:2};
    tbl[1]  = '{n:4, st:30'o2252,     er:0,  cm:0, dly:0, cnt:9,      ok:1, est:2, dec:7,    lastreq:5};
    tbl[2]  = '{n:8, st:30'o52525252, er:0,  cm:0, dly:0, cnt:1,      ok:0, est:0, dec:13,   lastreq:11};
    tbl[3]  = '{n:4, st:30'o3377,     er:0,  cm:0, dly:0, cnt:7,      ok:1, est:3, dec:7,    lastreq:5};
    tbl[4]  = '{n:4, st:30'o3333,     er:1,  cm:0, dly:0, cnt:3,      ok:1, est:3, dec:7,    lastreq:5};
    tbl[5]  = '{n:6, st:30'o333333,   er:9,  cm:0, dly:0, cnt:3,      ok:1, est:3, dec:10,   lastreq:8};
    tbl[6]  = '{n:4, st:30'o4444,     er:0,  cm:2, dly:0, cnt:16'h40, ok:1, est:4, dec:7,    lastreq:5};
    tbl[7]  = '{n:2, st:30'o66,       er:0,  cm:0, dly:1, cnt:2,      ok:1, est:6, dec:6,    lastreq:4};
    tbl[8]  = '{n:8, st:30'o77777777, er:0,  cm:0, dly:0, cnt:0,      ok:0, est:0, dec:13,   lastreq:11};
    tbl[9]  = '{n:1, st:30'o3,        er:0,  cm:0, dly:0, cnt:5,      ok:0, est:0, dec:1026, lastreq:1025};
    tbl[10] = '{n:2, st:30'o00,       er:0,  cm:0, dly:0, cnt:16'hFFFF, ok:1, est:0, dec:4,  lastreq:2};
    tbl[11] = '{n:8, st:30'o33525252, er:0,  cm:0, dly:0, cnt:8,      ok:1, est:3, dec:13,   lastreq:11};
    tbl[12] = '{n:2, st:30'o11,       er:0,  cm:0, dly:3, cnt:4,      ok:1, est:1, dec:10,   lastreq:8};

    for (int v = 0; v < NVEC; v++) begin
      apply_reset();
      chk_reset($sformatf("vec%0d reset", v));
      for (int r = 0; r < int'(tbl[v].n); r++)
        push_rd(st_word[tbl[v].st[3*r +: 3]], tbl[v].cnt ^ {15'd0, tbl[v].cm[r]},
                tbl[v].er[r], int'(tbl[v].dly));
      rst_i = 1'b0;
      observe($sformatf("vec%0d", v), 1'b0, tbl[v].ok, int'(tbl[v].dec),
              int'(tbl[v].lastreq), st_word[tbl[v].est], tbl[v].cnt);
    end

    // Ack arriving exactly on the terminal-count cycle of Read1 wins.
    apply_reset();
    push_rd(LcStProd, 16'd5, 1'b0, 0);
    push_rd(LcStProd, 16'd5, 1'b0, TIMEOUT - 1);
    rst_i = 1'b0;
    observe("ack_at_tc", 1'b0, 1'b1, 1027, 1025, LcStProd, 16'd5);

    // No ack at all in Read0.
    apply_reset();
    rst_i = 1'b0;
    observe("tmo_read0", 1'b0, 1'b0, 1025, 1024, '0, '0);

    // Refresh: matching value keeps valid high, differing value escalates.
    apply_reset();
    push_rd(LcStProd, 16'd5, 1'b0, 0);
    push_rd(LcStProd, 16'd5, 1'b0, 0);
    rst_i = 1'b0;
    observe("ref_init", 1'b0, 1'b1, 4, 2, LcStProd, 16'd5);
    clear_q();
    push_rd(LcStProd, 16'd5, 1'b0, 1);
    push_rd(LcStProd, 16'd5, 1'b0, 1);
    refresh_i = 1'b1;
    observe("ref_same", 1'b1, 1'b1, 6, 4, LcStProd, 16'd5);
    clear_q();
    push_rd(LcStDev, 16'd5, 1'b0, 0);
    push_rd(LcStDev, 16'd5, 1'b0, 0);
    refresh_i = 1'b1;
    observe("ref_diff", 1'b1, 1'b0, 4, 2, '0, '0);
    refresh_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    refresh_i = 1'b0;
    repeat (3) begin @(posedge clk_i); @(negedge clk_i); end
    chk("err_ignores_refresh req", otp_req_o, 0);
    chk("err_ignores_refresh err", fetch_err_o, 1);

    // Reset in the middle of a refresh Read0 drops everything, then refetch.
    apply_reset();
    push_rd(LcStProd, 16'd5, 1'b0, 0);
    push_rd(LcStProd, 16'd5, 1'b0, 0);
    rst_i = 1'b0;
    observe("rst_mid init", 1'b0, 1'b1, 4, 2, LcStProd, 16'd5);
    clear_q();
    push_rd(LcStProd, 16'd5, 1'b0, 5);
    refresh_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    refresh_i = 1'b0;
    chk("rst_mid in_read0 req", otp_req_o, 1);
    chk("rst_mid in_read0 valid", lc_state_valid_o, 1);
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    chk_reset("rst_mid");
    clear_q();
    push_rd(LcStScrap, 16'd6, 1'b0, 0);
    push_rd(LcStScrap, 16'd6, 1'b0, 0);
    rst_i = 1'b0;
    observe("rst_mid refetch", 1'b0, 1'b1, 4, 2, LcStScrap, 16'd6);

    // Randomized fetches and refreshes against the attempt-level model.
    for (int it = 0; it < 30; it++) begin
      apply_reset();
      bs = st_word[$urandom_range(0, 6)];
      bc = 16'($urandom);
      for (int r = 0; r < 8; r++) gen_read(bs, bc);
      rst_i = 1'b0;
      model(1'b0, '0, '0, m_ok, m_dec, m_lr, m_es, m_ec);
      observe($sformatf("rand%0d", it), 1'b0, m_ok, m_dec, m_lr, m_es, m_ec);
      if (m_ok && $urandom_range(0, 1) == 1) begin
        clear_q();
        bs = ($urandom_range(0, 3) != 0) ? m_es : st_word[$urandom_range(0, 6)];
        for (int r = 0; r < 8; r++) gen_read(bs, m_ec);
        refresh_i = 1'b1;
        model(1'b1, m_es, m_ec, m_ok, m_dec, m_lr, m_es, m_ec);
        observe($sformatf("rand%0d refresh", it), 1'b1, m_ok, m_dec, m_lr, m_es, m_ec);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
